// File: rtl/vx_om_req_serializer.sv
// Splits a multi-lane OM request into one fragment per active lane, lowest lane first.
// Optional performance counters are enabled with the macro VX_OM_SERIALIZER_PERF_EN.
module vx_om_req_serializer #(
   parameter int NUM_LANES  = 4,
   parameter int UUID_WIDTH = 44,
   parameter int DIM_BITS   = 15,
   parameter int DEPTH_BITS = 24,
   localparam int LANE_BITS = (NUM_LANES > 1) ? $clog2(NUM_LANES) : 1
) (
   input  logic                             clk,
   input  logic                             reset,

   input  logic                             req_valid,
   output logic                             req_ready,
   input  logic [UUID_WIDTH-1:0]            req_uuid,
   input  logic [NUM_LANES-1:0]             req_mask,
   input  logic [NUM_LANES*DIM_BITS-1:0]    req_pos_x,
   input  logic [NUM_LANES*DIM_BITS-1:0]    req_pos_y,
   input  logic [NUM_LANES*32-1:0]          req_color,
   input  logic [NUM_LANES*DEPTH_BITS-1:0]  req_depth,
   input  logic [NUM_LANES-1:0]             req_face,

   output logic                             frag_valid,
   input  logic                             frag_ready,
   output logic [UUID_WIDTH-1:0]            frag_uuid,
   output logic [LANE_BITS-1:0]             frag_lane,
   output logic [DIM_BITS-1:0]              frag_pos_x,
   output logic [DIM_BITS-1:0]              frag_pos_y,
   output logic [31:0]                      frag_color,
   output logic [DEPTH_BITS-1:0]            frag_depth,
   output logic                             frag_face,
   output logic                             frag_last
`ifdef VX_OM_SERIALIZER_PERF_EN
   ,
   output logic [31:0]                      perf_frags,
   output logic [31:0]                      perf_stalls
`endif
);

   typedef enum logic {IDLE, BUSY} state_t;

   state_t                            state;
   logic [NUM_LANES-1:0]              pending;
   logic [UUID_WIDTH-1:0]             uuid_r;
   logic [NUM_LANES*DIM_BITS-1:0]     pos_x_r;
   logic [NUM_LANES*DIM_BITS-1:0]     pos_y_r;
   logic [NUM_LANES*32-1:0]           color_r;
   logic [NUM_LANES*DEPTH_BITS-1:0]   depth_r;
   logic [NUM_LANES-1:0]              face_r;

   logic [DIM_BITS-1:0]               lane_x     [NUM_LANES];
   logic [DIM_BITS-1:0]               lane_y     [NUM_LANES];
   logic [31:0]                       lane_color [NUM_LANES];
   logic [DEPTH_BITS-1:0]             lane_depth [NUM_LANES];

   logic                              accept;
   logic                              frag_fire;
   logic [LANE_BITS-1:0]              lane_sel;

   for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
      assign lane_x[i]     = pos_x_r[i*DIM_BITS +: DIM_BITS];
      assign lane_y[i]     = pos_y_r[i*DIM_BITS +: DIM_BITS];
      assign lane_color[i] = color_r[i*32 +: 32];
      assign lane_depth[i] = depth_r[i*DEPTH_BITS +: DEPTH_BITS];
   end

   // Priority pick of the lowest pending lane; scanning downward lets the lowest hit win.
   always_comb begin
      lane_sel = '0;
      for (int i = NUM_LANES - 1; i >= 0; i--) begin
         if (pending[i]) lane_sel = LANE_BITS'(i);
      end
   end

   assign frag_valid = (state == BUSY);
   assign frag_lane  = lane_sel;
   assign frag_last  = (pending != '0) && ((pending & (pending - NUM_LANES'(1))) == '0);
   assign frag_fire  = frag_valid && frag_ready;
   assign req_ready  = (state == IDLE) || (frag_fire && frag_last);
   assign accept     = req_valid && req_ready;

   assign frag_uuid  = uuid_r;
   assign frag_pos_x = lane_x[lane_sel];
   assign frag_pos_y = lane_y[lane_sel];
   assign frag_color = lane_color[lane_sel];
   assign frag_depth = lane_depth[lane_sel];
   assign frag_face  = face_r[lane_sel];

   // Acceptance takes priority: it only happens while idle or on the final handshake,
   // so the old request is finished whenever a new one overwrites it.
   always_ff @(posedge clk) begin
      if (reset) begin
         state   <= IDLE;
         pending <= '0;
         uuid_r  <= '0;
         pos_x_r <= '0;
         pos_y_r <= '0;
         color_r <= '0;
         depth_r <= '0;
         face_r  <= '0;
      end else if (accept) begin
         state   <= (req_mask != '0) ? BUSY : IDLE;
         pending <= req_mask;
         uuid_r  <= req_uuid;
         pos_x_r <= req_pos_x;
         pos_y_r <= req_pos_y;
         color_r <= req_color;
         depth_r <= req_depth;
         face_r  <= req_face;
      end else if (frag_fire) begin
         pending <= pending & (pending - NUM_LANES'(1));
         if (frag_last) state <= IDLE;
      end
   end

`ifdef VX_OM_SERIALIZER_PERF_EN
   always_ff @(posedge clk) begin
      if (reset) begin
         perf_frags  <= '0;
         perf_stalls <= '0;
      end else begin
         if (frag_fire) perf_frags <= perf_frags + 32'd1;
         if (frag_valid && !frag_ready) perf_stalls <= perf_stalls + 32'd1;
      end
   end
`endif

endmodule

// File: doc/vx_om_req_serializer.md
VX_OM_REQ_SERIALIZER -- requirements
Module: VX_om_req_serializer

Interface
REQ-001 SHALL have parameter NUM_LANES, default 4: lanes per incoming OM bus request; legal values are 1 to 32.
REQ-002 SHALL have parameter UUID_WIDTH, default 44: width of the request tag.
REQ-003 SHALL have parameter DIM_BITS, default 15 (`VX_OM_DIM_BITS`): width of each pixel coordinate.
REQ-004 SHALL have parameter DEPTH_BITS, default 24 (`VX_OM_DEPTH_BITS`): width of each depth value.
REQ-005 SHALL have port clk, input, 1 bit: the single clock.
REQ-006 SHALL have port reset, input, 1 bit: reset, synchronous and active-high.
REQ-007 SHALL have the following request-side ports, all inputs except req_ready:
- req_valid, 1: OM request valid.
- req_ready, output, 1: request accepted on the cycle req_valid and req_ready are both high.
- req_uuid, UUID_WIDTH: request tag.
- req_mask, NUM_LANES: per-lane active mask.
- req_pos_x, NUM_LANES*DIM_BITS: x coordinate per lane; lane i occupies bits [i*DIM_BITS +: DIM_BITS].
- req_pos_y, NUM_LANES*DIM_BITS: y coordinate per lane, packed the same way.
- req_color, NUM_LANES*32: color per lane.
- req_depth, NUM_LANES*DEPTH_BITS: depth per lane.
- req_face, NUM_LANES: face bit per lane.
REQ-008 SHALL have the following fragment-side ports, all outputs except frag_ready:
- frag_valid, 1: fragment valid.
- frag_ready, input, 1: downstream accepts the fragment.
- frag_uuid, UUID_WIDTH: tag of the parent request.
- frag_lane, max(1, CLOG2(NUM_LANES)): lane index of the fragment.
- frag_pos_x, DIM_BITS: x coordinate.
- frag_pos_y, DIM_BITS: y coordinate.
- frag_color, 32: color.
- frag_depth, DEPTH_BITS: depth.
- frag_face, 1: face bit.
- frag_last, 1: last fragment of the current request.

Function
REQ-009 SHALL be a two-state FSM:
- IDLE: no request held.
- BUSY: a request is held and fragments remain.
REQ-010 SHALL, on request acceptance, latch all req_* fields and the mask into a pending-lane register.
REQ-011 SHALL drive req_ready = (state==IDLE) || (frag_valid && frag_ready && frag_last), allowing back-to-back requests with no bubble.
REQ-012 SHALL, when an accepted request has a nonzero mask, enter BUSY with frag_valid high on the next cycle.
- Latency from acceptance to first fragment is 1 cycle.
REQ-013 SHALL, when an accepted request has a zero mask, drop the request, emit no fragment and stay in (or return to) IDLE.
REQ-014 SHALL emit one fragment per set mask bit, in ascending lane order, with frag_lane equal to the index of the lowest set pending bit.
REQ-015 SHALL drive the frag_* data combinationally from the latched request, indexed by frag_lane.
REQ-016 SHALL hold frag_valid and all frag_* outputs stable while frag_valid && !frag_ready.
REQ-017 SHALL, on each handshake (frag_valid && frag_ready), clear the emitted lane's pending bit.
REQ-018 SHALL drive frag_last high exactly when one pending bit remains.
REQ-019 SHALL, on a handshake with frag_last high, return to IDLE unless a new request is accepted in the same cycle, in which case it stays BUSY with the new request and no bubble.
REQ-020 SHALL sustain one fragment per cycle while frag_ready is held high; a request with popcount P then completes in P cycles.
REQ-021 SHALL never drive frag_valid high in IDLE.

Reset
REQ-022 SHALL, while reset is high, force the following values, discarding any held request mid-operation:
- state = IDLE.
- pending mask = 0.
- frag_valid = 0.
- req_ready = 1.
REQ-023 SHALL drive frag data outputs to don't-care while frag_valid = 0; all latched data registers SHALL still reset to 0.

Configuration
REQ-024 SHALL, with macro VX_OM_SERIALIZER_PERF_EN defined, add two outputs, both reset to 0 and both wrapping on overflow:
- perf_frags, 32: count of fragment handshakes.
- perf_stalls, 32: cycles with frag_valid && !frag_ready.
REQ-025 SHALL, without VX_OM_SERIALIZER_PERF_EN, omit those ports and counters; all other behaviour is identical.

Verification
REQ-026 SHALL cover a full mask: NUM_LANES=4, req_mask=4'b1111, frag_ready=1 -> 4 fragments on 4 consecutive cycles, lanes 0,1,2,3, frag_last only on lane 3.
REQ-027 SHALL cover a sparse mask: req_mask=4'b1010, lane-1 color 0xAABBCCDD -> 2 fragments, lane 1 (color 0xAABBCCDD) then lane 3 with frag_last=1.
REQ-028 SHALL cover a zero mask: req_mask=0 -> req_ready stays 1, zero fragments, next request serviced normally.
REQ-029 SHALL cover back-pressure: frag_ready low for 3 cycles on lane 2 -> frag_* unchanged for those cycles; perf_stalls increments by 3 when PERF_EN is defined.
REQ-030 SHALL cover back-to-back requests: request A (mask 4'b0001) then request B (mask 4'b0011) held valid -> fragments A0, B0, B1 on consecutive cycles, frag_uuid switching with no gap.
REQ-031 SHALL cover reset mid-request: reset asserted after the 1st of 4 fragments -> frag_valid=0 on the next cycle, state IDLE, no remaining fragments emitted after reset deasserts.
